// File: rtl/hdmi_pattern_pkg.sv
// hdmi_pattern_pkg: shared constants, mode codes, colour table and the box
// motion helper for the 720p test-pattern source.
package hdmi_pattern_pkg;

    localparam logic [10:0] H_ACTIVE  = 11'd1280;
    localparam logic [10:0] V_ACTIVE  = 11'd720;
    localparam logic [10:0] BOX_SIZE  = 11'd64;
    localparam logic [10:0] BOX_STEP  = 11'd2;
    localparam logic [10:0] BAR_WIDTH = 11'd160;
    localparam logic [10:0] BOX_X_MAX = H_ACTIVE - BOX_SIZE;
    localparam logic [10:0] BOX_Y_MAX = V_ACTIVE - BOX_SIZE;

    typedef enum logic [1:0] {
        MODE_BARS = 2'd0,
        MODE_GRID = 2'd1,
        MODE_GRAD = 2'd2,
        MODE_BOX  = 2'd3
    } mode_e;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    // One axis of the bouncing box: position plus direction (1 = moving toward 0).
    typedef struct packed {
        logic [10:0] pos;
        logic        dir_neg;
    } box_axis_t;

    // Colour of the bar that contains column x; bar 7 and anything past it is black.
    function automatic logic [23:0] bar_color(input logic [10:0] x);
        logic [10:0] idx;
        idx = x / BAR_WIDTH;
        case (idx)
            11'd0:   return COL_WHITE;
            11'd1:   return COL_YELLOW;
            11'd2:   return COL_CYAN;
            11'd3:   return COL_GREEN;
            11'd4:   return COL_MAGENTA;
            11'd5:   return COL_RED;
            11'd6:   return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

    // One frame of box motion along an axis, clamping and reversing at both ends.
    function automatic box_axis_t box_step(input box_axis_t cur, input logic [10:0] lim);
        box_axis_t nxt;
        nxt = cur;
        if (!cur.dir_neg) begin
            if ((cur.pos + BOX_STEP) >= lim) begin
                nxt.pos     = lim;
                nxt.dir_neg = 1'b1;
            end else begin
                nxt.pos = cur.pos + BOX_STEP;
            end
        end else begin
            if (cur.pos <= BOX_STEP) begin
                nxt.pos     = 11'd0;
                nxt.dir_neg = 1'b0;
            end else begin
                nxt.pos = cur.pos - BOX_STEP;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hdmi_pattern_gen_btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stable-time filter for an active-low
// push-button; emits a one-cycle pulse on each debounced press (1->0).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 742500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Next-state: count while the synchronised level disagrees with the stable one.
    always_comb begin
        sync1_d  = btn_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers; the idle (released) button level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: 720p RGB test-pattern source (bars, grid, gradient,
// bouncing box) with sync re-aligned to a 2-cycle pixel pipeline.
// Optional build macro PATTERN_BORDER_EN adds a 1-pixel red frame border.
module hdmi_pattern_gen
    import hdmi_pattern_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 742500
) (
    input  logic        rgb_clk,
    input  logic        rgb_rst_n,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic [10:0] in_x,
    input  logic [10:0] in_y,
    input  logic        mode_btn,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_de,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic [1:0]  mode
);

    // Stage 1
    logic        hs1_q, vs1_q, de1_q;
    logic [10:0] x1_q, y1_q;
    // Stage 2
    logic        hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    logic [23:0] rgb_q, rgb_d;
    // Frame-rate state
    mode_e       mode_q, mode_d;
    logic        pending_q, pending_d;
    box_axis_t   bx_q, bx_d, by_q, by_d;

    logic        press_s;
    logic        frame_edge_s;
    logic        in_box_s;
    logic        grid_s;
    logic [23:0] pattern_s;
    logic [23:0] pix_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (rgb_clk),
        .rst_n (rgb_rst_n),
        .btn_n (mode_btn),
        .press (press_s)
    );

    assign frame_edge_s = in_vs & ~vs1_q;

    // Mode, pending-press flag and box position advance only on a frame edge.
    always_comb begin
        mode_d    = mode_q;
        bx_d      = bx_q;
        by_d      = by_q;
        pending_d = pending_q;
        if (frame_edge_s) begin
            bx_d = box_step(bx_q, BOX_X_MAX);
            by_d = box_step(by_q, BOX_Y_MAX);
            if (pending_q) begin
                mode_d = mode_e'(mode_q + 2'd1);
            end else begin
                mode_d = mode_q;
            end
        end else begin
            mode_d = mode_q;
        end
        // A press landing on the edge itself survives to the following frame.
        if (press_s) begin
            pending_d = 1'b1;
        end else if (frame_edge_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Pattern colour from the stage-1 coordinates.
    always_comb begin
        in_box_s = (x1_q >= bx_q.pos) && (x1_q < (bx_q.pos + BOX_SIZE)) &&
                   (y1_q >= by_q.pos) && (y1_q < (by_q.pos + BOX_SIZE));
        grid_s   = (x1_q[5:0] == 6'd0) || (y1_q[5:0] == 6'd0) ||
                   (x1_q == (H_ACTIVE - 11'd1)) || (y1_q == (V_ACTIVE - 11'd1));
        case (mode_q)
            MODE_BARS: pattern_s = bar_color(x1_q);
            MODE_GRID: pattern_s = grid_s ? COL_WHITE : COL_BLACK;
            MODE_GRAD: pattern_s = {x1_q[10:3], y1_q[9:2], 8'h80};
            MODE_BOX:  pattern_s = in_box_s ? COL_WHITE : COL_BLUE;
            default:   pattern_s = COL_BLACK;
        endcase
`ifdef PATTERN_BORDER_EN
        if ((x1_q == 11'd0) || (x1_q == (H_ACTIVE - 11'd1)) ||
            (y1_q == 11'd0) || (y1_q == (V_ACTIVE - 11'd1))) begin
            pix_s = COL_RED;
        end else begin
            pix_s = pattern_s;
        end
`else
        pix_s = pattern_s;
`endif
    end

    // Stage-2 next values; colour is forced to black outside the active area.
    always_comb begin
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        de2_d = de1_q;
        if (de1_q) begin
            rgb_d = pix_s;
        end else begin
            rgb_d = COL_BLACK;
        end
    end

    // Pipeline and frame-state registers.
    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de1_q     <= 1'b0;
            x1_q      <= 11'd0;
            y1_q      <= 11'd0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            de2_q     <= 1'b0;
            rgb_q     <= 24'h000000;
            mode_q    <= MODE_BARS;
            pending_q <= 1'b0;
            bx_q      <= '{pos: 11'd0, dir_neg: 1'b0};
            by_q      <= '{pos: 11'd0, dir_neg: 1'b0};
        end else begin
            hs1_q     <= in_hs;
            vs1_q     <= in_vs;
            de1_q     <= in_de;
            x1_q      <= in_x;
            y1_q      <= in_y;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            de2_q     <= de2_d;
            rgb_q     <= rgb_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
        end
    end

    assign out_hs = hs2_q;
    assign out_vs = vs2_q;
    assign out_de = de2_q;
    assign out_r  = rgb_q[23:16];
    assign out_g  = rgb_q[15:8];
    assign out_b  = rgb_q[7:0];
    assign mode   = mode_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: directed self-checking bench for hdmi_pattern_gen.
// Uses a short debounce time so button scenarios fit in a short run.
module tb_hdmi_pattern_gen;

    localparam int DEB = 32;

    logic        rgb_clk;
    logic        rgb_rst_n;
    logic        in_hs, in_vs, in_de;
    logic [10:0] in_x, in_y;
    logic        mode_btn;
    logic        out_hs, out_vs, out_de;
    logic [7:0]  out_r, out_g, out_b;
    logic [1:0]  mode;

    int n_checks = 0;
    int n_errors = 0;
    int nfr = 0;

    hdmi_pattern_gen #(.DEBOUNCE_CYCLES(DEB)) dut (
        .rgb_clk   (rgb_clk),
        .rgb_rst_n (rgb_rst_n),
        .in_hs     (in_hs),
        .in_vs     (in_vs),
        .in_de     (in_de),
        .in_x      (in_x),
        .in_y      (in_y),
        .mode_btn  (mode_btn),
        .out_hs    (out_hs),
        .out_vs    (out_vs),
        .out_de    (out_de),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .mode      (mode)
    );

    initial rgb_clk = 1'b0;
    always #5 rgb_clk = ~rgb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected colour after the optional red border overrides the pattern.
    function automatic logic [23:0] brd(input logic [10:0] x, input logic [10:0] y,
                                        input logic [23:0] c);
`ifdef PATTERN_BORDER_EN
        if (x == 11'd0 || x == 11'd1279 || y == 11'd0 || y == 11'd719) return 24'hFF0000;
`endif
        return c;
    endfunction

    // One active pixel; checked two cycles after it is presented.
    task automatic px(input string tag, input logic [10:0] x, input logic [10:0] y,
                      input logic [23:0] c);
        in_de = 1'b1; in_x = x; in_y = y;
        @(negedge rgb_clk);
        in_de = 1'b0; in_x = 11'd0; in_y = 11'd0;
        @(negedge rgb_clk);
        check({tag, "_de"}, {31'd0, out_de}, 32'd1);
        check(tag, {8'd0, out_r, out_g, out_b}, {8'd0, brd(x, y, c)});
    endtask

    // One vsync pulse (frame edge); also checks the delayed vsync.
    task automatic frame();
        in_vs = 1'b1;
        @(negedge rgb_clk);
        in_vs = 1'b0;
        @(negedge rgb_clk);
        check("vs_delay", {31'd0, out_vs}, 32'd1);
        @(negedge rgb_clk);
        nfr++;
    endtask

    task automatic press(input int len);
        mode_btn = 1'b0;
        repeat (len) @(negedge rgb_clk);
        mode_btn = 1'b1;
        repeat (DEB + 5) @(negedge rgb_clk);
    endtask

    task automatic run_to(input int n);
        while (nfr < n) frame();
    endtask

    initial begin
        rgb_rst_n = 1'b0;
        in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0;
        in_x = 11'd0; in_y = 11'd0;
        mode_btn = 1'b1;
        repeat (3) @(negedge rgb_clk);
        check("rst_de", {31'd0, out_de}, 32'd0);
        check("rst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        check("rst_mode", {30'd0, mode}, 32'd0);
        rgb_rst_n = 1'b1;
        @(negedge rgb_clk);

        // Latency is exactly two cycles: not visible after one.
        in_de = 1'b1; in_x = 11'd0; in_y = 11'd0;
        @(negedge rgb_clk);
        in_de = 1'b0;
        check("lat1_de", {31'd0, out_de}, 32'd0);
        @(negedge rgb_clk);
        check("lat2_de", {31'd0, out_de}, 32'd1);
        check("bar_0_0", {8'd0, out_r, out_g, out_b}, {8'd0, brd(11'd0, 11'd0, 24'hFFFFFF)});
        @(negedge rgb_clk);
        check("blank_de", {31'd0, out_de}, 32'd0);
        check("blank_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);

        // Colour bars
        px("bar_1279", 11'd1279, 11'd5, 24'h000000);
        px("bar_160",  11'd160,  11'd5, 24'hFFFF00);
        px("bar_159",  11'd159,  11'd5, 24'hFFFFFF);
        px("bar_320",  11'd320,  11'd5, 24'h00FFFF);
        px("bar_480",  11'd480,  11'd5, 24'h00FF00);
        px("bar_640",  11'd640,  11'd5, 24'hFF00FF);
        px("bar_800",  11'd800,  11'd5, 24'hFF0000);
        px("bar_960",  11'd960,  11'd5, 24'h0000FF);
        px("bar_1120", 11'd1120, 11'd5, 24'h000000);

        // hsync path
        in_hs = 1'b1;
        @(negedge rgb_clk);
        in_hs = 1'b0;
        @(negedge rgb_clk);
        check("hs_delay", {31'd0, out_hs}, 32'd1);

        // Valid press mid-frame: applied only at the next frame edge.
        press(DEB + 5);
        check("mode_before_edge", {30'd0, mode}, 32'd0);
        frame();
        check("mode_grid", {30'd0, mode}, 32'd1);
        px("grid_64_5",   11'd64,   11'd5,   24'hFFFFFF);
        px("grid_65_5",   11'd65,   11'd5,   24'h000000);
        px("grid_65_64",  11'd65,   11'd64,  24'hFFFFFF);
        px("grid_1279_9", 11'd1279, 11'd9,   24'hFFFFFF);
        px("grid_65_719", 11'd65,   11'd719, 24'hFFFFFF);

        // Glitch shorter than the debounce time is ignored.
        press(DEB - 10);
        frame();
        check("mode_glitch", {30'd0, mode}, 32'd1);

        // Three presses within one frame give one step.
        press(DEB + 5);
        press(DEB + 5);
        press(DEB + 5);
        frame();
        check("mode_grad", {30'd0, mode}, 32'd2);
        px("grad_8_100",   11'd8,   11'd100, 24'h011980);
        px("grad_0_100",   11'd0,   11'd100, 24'h001980);
        px("grad_800_400", 11'd800, 11'd400, 24'h646480);

        // Press flag set on the same cycle as the frame edge: deferred one frame.
        mode_btn = 1'b0;
        repeat (DEB + 2) @(negedge rgb_clk);
        frame();
        check("mode_coincide", {30'd0, mode}, 32'd2);
        mode_btn = 1'b1;
        repeat (DEB + 5) @(negedge rgb_clk);
        frame();
        check("mode_box", {30'd0, mode}, 32'd3);

        // Box: nfr = 5 -> bx = by = 10
        px("box5_in",   11'd10, 11'd10, 24'hFFFFFF);
        px("box5_l",    11'd9,  11'd10, 24'h0000FF);
        px("box5_br",   11'd73, 11'd73, 24'hFFFFFF);
        px("box5_r",    11'd74, 11'd10, 24'h0000FF);
        px("box5_b",    11'd10, 11'd74, 24'h0000FF);
        run_to(328);   // bx = by = 656, y clamped
        px("box328_in", 11'd656, 11'd656, 24'hFFFFFF);
        px("box328_t",  11'd656, 11'd655, 24'h0000FF);
        px("box328_l",  11'd655, 11'd656, 24'h0000FF);
        px("box328_br", 11'd719, 11'd719, 24'hFFFFFF);
        run_to(329);   // bx = 658, by = 654
        px("box329_in", 11'd658, 11'd654, 24'hFFFFFF);
        px("box329_l",  11'd657, 11'd654, 24'h0000FF);
        px("box329_br", 11'd721, 11'd717, 24'hFFFFFF);
        px("box329_r",  11'd722, 11'd717, 24'h0000FF);
        run_to(608);   // bx = 1216 (clamped), by = 96
        px("box608_in", 11'd1216, 11'd96,  24'hFFFFFF);
        px("box608_l",  11'd1215, 11'd96,  24'h0000FF);
        px("box608_br", 11'd1279, 11'd159, 24'hFFFFFF);
        px("box608_b",  11'd1279, 11'd160, 24'h0000FF);
        run_to(609);   // bx = 1214, by = 94
        px("box609_in", 11'd1214, 11'd94,  24'hFFFFFF);
        px("box609_r",  11'd1278, 11'd94,  24'h0000FF);
        px("box609_br", 11'd1277, 11'd157, 24'hFFFFFF);
        run_to(656);   // bx = 1120, by = 0 (clamped)
        px("box656_in", 11'd1120, 11'd0,  24'hFFFFFF);
        px("box656_b",  11'd1120, 11'd64, 24'h0000FF);
        px("box656_l",  11'd1119, 11'd5,  24'h0000FF);
        px("box656_br", 11'd1183, 11'd63, 24'hFFFFFF);
        run_to(657);   // bx = 1118, by = 2
        px("box657_in", 11'd1118, 11'd2,  24'hFFFFFF);
        px("box657_t",  11'd1118, 11'd1,  24'h0000FF);
        px("box657_br", 11'd1181, 11'd65, 24'hFFFFFF);
        px("box657_r",  11'd1182, 11'd65, 24'h0000FF);
        check("mode_still_box", {30'd0, mode}, 32'd3);

        // Asynchronous reset mid-line.
        in_hs = 1'b1; in_de = 1'b1; in_x = 11'd160; in_y = 11'd3;
        @(negedge rgb_clk);
        @(negedge rgb_clk);
        check("pre_rst_de", {31'd0, out_de}, 32'd1);
        #2 rgb_rst_n = 1'b0;
        #1;
        check("arst_de",   {31'd0, out_de}, 32'd0);
        check("arst_hs",   {31'd0, out_hs}, 32'd0);
        check("arst_rgb",  {8'd0, out_r, out_g, out_b}, 32'd0);
        check("arst_mode", {30'd0, mode}, 32'd0);
        @(negedge rgb_clk);
        in_hs = 1'b0; in_de = 1'b0; in_x = 11'd0; in_y = 11'd0;
        rgb_rst_n = 1'b1;
        @(negedge rgb_clk);
        px("post_rst_bar", 11'd160, 11'd3, 24'hFFFF00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
